// File: rtl/trs80_bus_ctrl.sv
// TRS-80 Model I style bus controller for a Z80 core.
// Decodes CPU memory cycles into device selects and a read-data mux.
// Inserts per-region wait states and issues a single-cycle write strobe.
// Generates the periodic timer interrupt and a stretched system reset.
//
// Ports:
//   clock, reset_n, soft_reset           clocking, async reset, restart request
//   cpu_mreq_n/iorq_n/m1_n/rd_n/wr_n     Z80 bus strobes
//   cpu_addr                             Z80 address bus
//   rom/ram/vram/kbd_dout                device read data
//   cpu_din, cpu_wait_n, cpu_int_n       data, WAIT_n and INT_n back to the Z80
//   rom/ram/vram/kbd_cs_n                active-low device selects
//   mem_we                               one-cycle write strobe
//   sys_reset_n                          stretched reset for the rest of the system
module trs80_bus_ctrl #(
    parameter int          ROM_AW      = 12,
    parameter logic [15:0] RAM_BASE    = 16'h4000,
    parameter int          RAM_AW      = 12,
    parameter logic [15:0] VRAM_BASE   = 16'h3C00,
    parameter logic [15:0] KBD_BASE    = 16'h3800,
    parameter logic [15:0] IRQ_ADDR    = 16'h37E0,
    parameter int          ROM_WAIT    = 0,
    parameter int          RAM_WAIT    = 0,
    parameter int          TICK_DIV    = 100000,
    parameter int          RST_STRETCH = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        soft_reset,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_m1_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  rom_dout,
    input  logic [7:0]  ram_dout,
    input  logic [7:0]  vram_dout,
    input  logic [7:0]  kbd_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_wait_n,
    output logic        cpu_int_n,
    output logic        rom_cs_n,
    output logic        ram_cs_n,
    output logic        vram_cs_n,
    output logic        kbd_cs_n,
    output logic        mem_we,
    output logic        sys_reset_n
);

    localparam logic [16:0] ROM_END = 17'd1 << ROM_AW;
    localparam logic [16:0] RAM_END = {1'b0, RAM_BASE} + (17'd1 << RAM_AW);
    localparam logic [3:0]  ROM_W   = 4'(ROM_WAIT);
    localparam logic [3:0]  RAM_W   = 4'(RAM_WAIT);
    localparam int          TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int          RSW     = (RST_STRETCH > 0) ? $clog2(RST_STRETCH + 1) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RSW-1:0] RST_MAX   = RSW'(RST_STRETCH);

    typedef enum logic [2:0] {REG_NONE, REG_IRQ, REG_KBD, REG_VRAM, REG_ROM, REG_RAM} region_t;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    region_t        region;
    state_t         state, state_next;
    logic [3:0]     wait_cnt, wait_cnt_next, region_wait;
    logic           we_next, we_region, armed, access_start, hold_off;
    logic           irq_pending, irq_next, irq_read_seen, irq_clear, tick_wrap;
    logic [TW-1:0]  tick_cnt;
    logic [RSW-1:0] rst_cnt, rst_cnt_next;

    // Address decode; the if/else order is the region priority, IRQ byte first.
    always_comb begin
        if (cpu_addr == IRQ_ADDR)                                       region = REG_IRQ;
        else if (cpu_addr[15:8] == KBD_BASE[15:8])                      region = REG_KBD;
        else if (cpu_addr[15:10] == VRAM_BASE[15:10])                   region = REG_VRAM;
        else if ({1'b0, cpu_addr} < ROM_END)                            region = REG_ROM;
        else if (cpu_addr >= RAM_BASE && {1'b0, cpu_addr} < RAM_END)    region = REG_RAM;
        else                                                            region = REG_NONE;
    end

    assign rom_cs_n  = !(!cpu_mreq_n && region == REG_ROM);
    assign ram_cs_n  = !(!cpu_mreq_n && region == REG_RAM);
    assign vram_cs_n = !(!cpu_mreq_n && region == REG_VRAM);
    assign kbd_cs_n  = !(!cpu_mreq_n && region == REG_KBD);

    // Read mux; IO cycles and unmapped space float high like an open bus.
    always_comb begin
        cpu_din = 8'hFF;
        if (!cpu_mreq_n) begin
            case (region)
                REG_IRQ:  cpu_din = {irq_pending, 7'b0};
                REG_KBD:  cpu_din = kbd_dout;
                REG_VRAM: cpu_din = vram_dout;
                REG_ROM:  cpu_din = rom_dout;
                REG_RAM:  cpu_din = ram_dout;
                default:  cpu_din = 8'hFF;
            endcase
        end
    end

    assign region_wait = (region == REG_ROM) ? ROM_W : (region == REG_RAM) ? RAM_W : 4'd0;
    assign we_region   = (region != REG_ROM) && (region != REG_NONE);
    // armed remembers that MREQ_n has been seen high, so only one access starts per MREQ_n low period.
    assign access_start = armed && !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
    assign hold_off     = !sys_reset_n || soft_reset;
    assign cpu_wait_n   = (state != WAIT);

    // Wait-state sequencing: WAIT lasts exactly wait_cnt cycles, and the write strobe
    // is raised only on the transition into HOLD.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        we_next       = 1'b0;
        if (hold_off) begin
            state_next    = IDLE;
            wait_cnt_next = 4'd0;
        end else begin
            case (state)
                IDLE: if (access_start) begin
                    if (region_wait != 4'd0) begin
                        state_next    = WAIT;
                        wait_cnt_next = region_wait;
                    end else begin
                        state_next = HOLD;
                        we_next    = !cpu_wr_n && we_region;
                    end
                end
                WAIT: begin
                    wait_cnt_next = wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state_next = HOLD;
                        we_next    = !cpu_wr_n && we_region;
                    end
                end
                HOLD:    if (cpu_mreq_n) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            mem_we   <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            mem_we   <= we_next;
            if (soft_reset)       armed <= 1'b0;
            else if (cpu_mreq_n)  armed <= 1'b1;
            else if (access_start) armed <= 1'b0;
        end
    end

    // Interrupt source: a tick wrap always wins over a clear landing in the same cycle.
    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign irq_clear = (irq_read_seen && cpu_mreq_n) || (!cpu_m1_n && !cpu_iorq_n);

    always_comb begin
        irq_next = irq_pending;
        if (hold_off)       irq_next = 1'b0;
        else if (tick_wrap) irq_next = 1'b1;
        else if (irq_clear) irq_next = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt      <= '0;
            irq_pending   <= 1'b0;
            cpu_int_n     <= 1'b1;
            irq_read_seen <= 1'b0;
        end else begin
            if (hold_off || tick_wrap) tick_cnt <= '0;
            else                       tick_cnt <= tick_cnt + TW'(1);
            irq_pending   <= irq_next;
            cpu_int_n     <= ~irq_next;
            irq_read_seen <= !cpu_mreq_n && (irq_read_seen || (!cpu_rd_n && region == REG_IRQ));
        end
    end

    // Reset stretcher; sys_reset_n is registered from the next count so it never glitches.
    always_comb begin
        if (soft_reset)              rst_cnt_next = '0;
        else if (rst_cnt == RST_MAX) rst_cnt_next = rst_cnt;
        else                         rst_cnt_next = rst_cnt + RSW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt     <= '0;
            sys_reset_n <= 1'b0;
        end else begin
            rst_cnt     <= rst_cnt_next;
            sys_reset_n <= (rst_cnt_next == RST_MAX);
        end
    end

endmodule

// File: doc/trs80_bus_ctrl.md
TRS80_BUS_CTRL -- requirements
Module: trs80_bus_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ROM_AW, 12: ROM address width; ROM spans 0x0000..2^ROM_AW-1.
- RAM_BASE, 16'h4000: RAM base address.
- RAM_AW, 12: RAM address width; RAM spans RAM_BASE..RAM_BASE+2^RAM_AW-1.
- VRAM_BASE, 16'h3C00: 1KB VRAM window base.
- KBD_BASE, 16'h3800: 256B keyboard window base.
- IRQ_ADDR, 16'h37E0: interrupt status/ack byte.
- ROM_WAIT, 0: wait cycles on ROM access (0..15).
- RAM_WAIT, 0: wait cycles on RAM access (0..15).
- TICK_DIV, 100000: clock cycles per timer tick (40Hz at 4MHz).
- RST_STRETCH, 255: cycles sys_reset_n is held low after reset release.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1: CPU clock; all state is clocked on its rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- soft_reset, in, 1: synchronous restart request (OSD/ARM/download).
- cpu_mreq_n / cpu_iorq_n / cpu_m1_n / cpu_rd_n / cpu_wr_n, in, 1 each: Z80 strobes.
- cpu_addr, in, 16: CPU address.
- rom_dout / ram_dout / vram_dout / kbd_dout, in, 8 each: device read data.
- cpu_din, out, 8: read data to the CPU.
- cpu_wait_n, out, 1: Z80 WAIT_n.
- cpu_int_n, out, 1: Z80 INT_n.
- rom_cs_n / ram_cs_n / vram_cs_n / kbd_cs_n, out, 1 each: active-low selects.
- mem_we, out, 1: single-cycle write strobe.
- sys_reset_n, out, 1: stretched system reset.

Function
REQ-003 Decode is combinational from cpu_addr while cpu_mreq_n=0, in fixed priority: IRQ_ADDR > KBD > VRAM > ROM > RAM. The highest matching region alone asserts its select. Every select is high while cpu_mreq_n=1.
REQ-004 cpu_din is the selected device's data. An IRQ_ADDR read returns {irq_pending,7'b0}. An unmapped read or an IO read returns 8'hFF.
REQ-005 Access start is the first cycle with cpu_mreq_n=0 and (cpu_rd_n=0 or cpu_wr_n=0) after a cycle with cpu_mreq_n=1.
REQ-006 Wait-state FSM states: IDLE, WAIT, HOLD.
- IDLE: on access start to a region with W>0, load counter=W, drive cpu_wait_n=0, go to WAIT. If W=0, go directly to HOLD.
- WAIT: decrement each cycle. When the counter reaches 0, release cpu_wait_n and go to HOLD. This gives exactly W cycles low.
- HOLD: stay until cpu_mreq_n=1, then return to IDLE.
REQ-007 cpu_wait_n is 1 in every state except WAIT, and is 1 for all non-ROM/RAM regions.
REQ-008 mem_we pulses for exactly one cycle on the first HOLD-entry cycle where cpu_wr_n=0. The pulse is suppressed for ROM and unmapped writes. No second pulse occurs before the FSM returns to IDLE.
REQ-009 Tick counter:
- Counts 0..TICK_DIV-1, then wraps to 0.
- The wrap cycle sets irq_pending.
REQ-010 irq_pending clears on either:
- the cycle after an IRQ_ADDR read completes (cpu_mreq_n rising), or
- an interrupt acknowledge (cpu_m1_n=0 and cpu_iorq_n=0).
If a tick wrap and a clear fall in the same cycle, irq_pending stays 1.
REQ-011 cpu_int_n = ~irq_pending, registered.
REQ-012 Reset stretch counter:
- Reloads to 0 on reset_n=0 or soft_reset=1.
- Otherwise increments, saturating at RST_STRETCH.
- sys_reset_n=0 until the count equals RST_STRETCH.
REQ-013 While sys_reset_n=0, the block holds:
- wait FSM in IDLE,
- tick counter at 0,
- irq_pending at 0,
- mem_we at 0.
REQ-014 A soft_reset mid-access aborts the access: cpu_wait_n goes to 1 next cycle and no mem_we is issued.

Reset
REQ-015 On reset_n=0, asynchronously:
- cpu_wait_n=1, cpu_int_n=1, mem_we=0, sys_reset_n=0.
- FSM=IDLE, all counters=0, irq_pending=0.
- Selects follow REQ-003 combinationally.
REQ-016 Reset release is synchronous. sys_reset_n rises exactly RST_STRETCH clocks after the first rising edge with reset_n=1 and soft_reset=0.

Verification
REQ-017 Decode sweep: read 0x0000, 0x37E0, 0x3800, 0x3C00, 0x4000, 0x8000 -> rom/irq/kbd/vram/ram/none selects as expected; cpu_din=8'hFF at 0x8000.
REQ-018 Wait states, RAM_WAIT=3: RAM read -> cpu_wait_n low for exactly 3 cycles. Same test with ROM_WAIT=0 -> cpu_wait_n never low.
REQ-019 Writes: write 0x4000 -> exactly one mem_we pulse. Write 0x0100 -> no mem_we.
REQ-020 Interrupt, TICK_DIV=10:
- cpu_int_n falls 10 cycles after reset stretch ends.
- Read 0x37E0 -> data 8'h80, then cpu_int_n=1.
- Force a tick wrap on the clear cycle -> cpu_int_n stays 0.
REQ-021 Reset, RST_STRETCH=4:
- Release reset_n -> sys_reset_n rises on the 4th edge.
- Pulse soft_reset during a WAIT -> cpu_wait_n=1 next cycle, sys_reset_n low for 4 cycles, no mem_we.
